seq_generator: RTL and testbench



---
 rtl/seq_generator.sv | 166 ++++++++++++++++
 tb/tb_seq_generator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_generator.sv
// -----------------------------------------------------------------------------
// seq_generator
//
// Bit-serial sequence transmitter. A start request captures a WIDTH-bit
// pattern and a repeat count, then the pattern is driven MSB-first on
// sequence_out, one bit per clock, for (repeat_in + 1) repetitions.
//
// Optional feature macro: SEQGEN_GAP_EN
//   defined   -> a single 0 bit (GAP state) is inserted between consecutive
//                repetitions, never before the first or after the last.
//   undefined -> repetitions are strictly back-to-back.
//
// Parameters:
//   WIDTH        pattern length in bits (min 2)
//   CNT_W        width of the repeat-count input
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset (0 = reset asserted)
//   start        burst request, sampled on the rising edge
//   pattern_in   pattern to send, captured when start is accepted
//   repeat_in    extra repetitions (0 = send once), captured with pattern_in
//   sequence_out registered serial data
//   busy         burst in progress (registered)
//   done         one-cycle pulse coincident with the last data bit (registered)
// -----------------------------------------------------------------------------
module seq_generator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_in,
    output logic             sequence_out,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
`ifdef SEQGEN_GAP_EN
        SHIFT,
        GAP
`else
        SHIFT
`endif
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] pat_d;
    logic [BW-1:0]    bit_q;
    logic [BW-1:0]    bit_d;
    logic [CNT_W-1:0] rep_q;
    logic [CNT_W-1:0] rep_d;
    logic             seq_d;
    logic             busy_d;
    logic             done_d;
    logic             last_bit;
    logic             accept;

    // The final data bit of a burst is on the line when both counters are
    // exhausted. A start is honoured when idle or during that final bit, which
    // lets a new burst follow the old one with no idle cycle in between.
    assign last_bit = (state_q == SHIFT) && (bit_q == '0) && (rep_q == '0);
    assign accept   = start && ((state_q == IDLE) || last_bit);

    // State register. The serial outputs are registered here too so that
    // nothing on the output pins depends combinationally on the inputs; their
    // next values come from the output logic below, which looks at the
    // upcoming state rather than the current one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            pat_q        <= '0;
            bit_q        <= '0;
            rep_q        <= '0;
            sequence_out <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            pat_q        <= pat_d;
            bit_q        <= bit_d;
            rep_q        <= rep_d;
            sequence_out <= seq_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Next-state logic. shreg_q holds the remaining bits of the current
    // repetition with the bit on the line at its MSB; pat_q keeps an untouched
    // copy so each repetition can be reloaded. bit_q counts the bits still to
    // follow the one on the line, rep_q the repetitions still to follow.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        pat_d   = pat_q;
        bit_d   = bit_q;
        rep_d   = rep_q;

        if (accept) begin
            state_d = SHIFT;
            shreg_d = pattern_in;
            pat_d   = pattern_in;
            bit_d   = LAST_BIT;
            rep_d   = repeat_in;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SHIFT: begin
                    if (bit_q != '0) begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        bit_d   = bit_q - 1'b1;
                    end else if (rep_q != '0) begin
                        rep_d   = rep_q - 1'b1;
                        shreg_d = pat_q;
                        bit_d   = LAST_BIT;
`ifdef SEQGEN_GAP_EN
                        state_d = GAP;
`endif
                    end else begin
                        state_d = IDLE;
                        shreg_d = '0;
                    end
                end
`ifdef SEQGEN_GAP_EN
                GAP: begin
                    state_d = SHIFT;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output logic, evaluated on the upcoming state so the registered outputs
    // line up with the bit they describe. The line is forced low outside
    // SHIFT, which covers both idle and the inter-repetition gap.
    always_comb begin
        seq_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d == SHIFT) begin
            seq_d  = shreg_d[WIDTH-1];
            done_d = (bit_d == '0) && (rep_d == '0);
        end
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_seq_generator.sv
// -----------------------------------------------------------------------------
// tb_seq_generator
//
// Self-checking bench for seq_generator. A reference model keeps the bits a
// burst should still put on the line in a queue: an accepted start appends
// the whole burst (pattern MSB-first, repeated, with optional gap zeros), and
// each clock edge consumes one entry. The expected outputs follow directly:
// line = head of queue, busy = queue not empty, done = one entry left.
// Directed scenarios add fixed expected bit strings on top of the model.
// -----------------------------------------------------------------------------
module tb_seq_generator;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
`ifdef SEQGEN_GAP_EN
    localparam int GAP_EN = 1;
`else
    localparam int GAP_EN = 0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] pattern_in;
    logic [CNT_W-1:0] repeat_in;
    logic             sequence_out;
    logic             busy;
    logic             done;

    int          errors = 0;
    int          checks = 0;
    bit          exp_q[$];
    logic [31:0] obs_bits;
    int          done_cnt;
    int          busy_cnt;

    always #5 clock = ~clock;

    seq_generator #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pattern_in   (pattern_in),
        .repeat_in    (repeat_in),
        .sequence_out (sequence_out),
        .busy         (busy),
        .done         (done)
    );

    // Reference model: a start is accepted when at most one bit (the final
    // one) remains; the remaining bit is consumed and the new burst follows.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            automatic bit can_start = (exp_q.size() <= 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (can_start && start) begin
                for (int r = 0; r <= int'(repeat_in); r++) begin
                    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(pattern_in[i]);
                    if (GAP_EN != 0 && r < int'(repeat_in)) exp_q.push_back(1'b0);
                end
            end
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Sample on the falling edge, compare against the model, log the bit.
    task automatic sampleCycle();
        logic exp_seq;
        @(negedge clock);
        exp_seq = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
        checkOutput("sequence_out", 32'(sequence_out), 32'(exp_seq));
        checkOutput("busy", 32'(busy), 32'(exp_q.size() > 0));
        checkOutput("done", 32'(done), 32'(exp_q.size() == 1));
        obs_bits = {obs_bits[30:0], sequence_out};
        done_cnt += int'(done);
        busy_cnt += int'(busy);
    endtask

    task automatic driveInputs(input logic s, input logic [WIDTH-1:0] p,
                               input logic [CNT_W-1:0] r);
        start      = s;
        pattern_in = p;
        repeat_in  = r;
    endtask

    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] p,
                                 input logic [CNT_W-1:0] r);
        sampleCycle();
        driveInputs(s, p, r);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 4'($urandom), 4'($urandom));
    endtask

    task automatic clearObs();
        obs_bits = '0;
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    initial begin
        reset = 1'b0;
        driveInputs(1'b0, '0, '0);
        clearObs();

        // Reset state.
        for (int k = 0; k < 3; k++) sampleCycle();

        // Single 1101 burst, started on the first edge after reset release.
        reset = 1'b1;
        driveInputs(1'b1, 4'b1101, 4'd0);
        clearObs();
        idleCycles(4);
        checkOutput("t1_bits", obs_bits, 32'b1101);
        checkOutput("t1_done_pulses", 32'(done_cnt), 32'd1);
        checkOutput("t1_busy_cycles", 32'(busy_cnt), 32'd4);
        idleCycles(3);

        // Three repetitions.
        applyStimulus(1'b1, 4'b1101, 4'd2);
        clearObs();
        idleCycles(12 + 2 * GAP_EN);
`ifdef SEQGEN_GAP_EN
        checkOutput("t2_bits", obs_bits, 32'b11010110101101);
`else
        checkOutput("t2_bits", obs_bits, 32'b110111011101);
`endif
        checkOutput("t2_done_pulses", 32'(done_cnt), 32'd1);
        idleCycles(3);

        // Start and pattern changes mid-burst are ignored.
        applyStimulus(1'b1, 4'b1101, 4'd0);
        clearObs();
        applyStimulus(1'b1, 4'b0110, 4'd3);
        applyStimulus(1'b1, 4'b0110, 4'd3);
        applyStimulus(1'b0, 4'b0110, 4'd3);
        applyStimulus(1'b0, 4'b0110, 4'd3);
        checkOutput("t3_bits", obs_bits, 32'b1101);
        checkOutput("t3_done_pulses", 32'(done_cnt), 32'd1);
        idleCycles(3);

        // Restart on the done cycle: contiguous bursts.
        applyStimulus(1'b1, 4'b1101, 4'd0);
        clearObs();
        idleCycles(3);
        applyStimulus(1'b1, 4'b1011, 4'd0);
        idleCycles(4);
        checkOutput("t4_bits", obs_bits, 32'b11011011);
        checkOutput("t4_done_pulses", 32'(done_cnt), 32'd2);
        checkOutput("t4_busy_cycles", 32'(busy_cnt), 32'd8);
        idleCycles(3);

        // Asynchronous reset on the third bit of a burst.
        applyStimulus(1'b1, 4'b1101, 4'd3);
        idleCycles(2);
        sampleCycle();
        #2 reset = 1'b0;
        #1;
        checkOutput("t5_async_seq", 32'(sequence_out), 32'd0);
        checkOutput("t5_async_busy", 32'(busy), 32'd0);
        checkOutput("t5_async_done", 32'(done), 32'd0);
        sampleCycle();
        sampleCycle();
        reset = 1'b1;
        clearObs();
        idleCycles(6);
        checkOutput("t5_quiet_bits", obs_bits, 32'd0);
        checkOutput("t5_quiet_busy", 32'(busy_cnt), 32'd0);

        // Maximum repeat count: 16 repetitions, 64 data bits.
        applyStimulus(1'b1, 4'b1001, 4'hF);
        clearObs();
        idleCycles(64 + 15 * GAP_EN);
        checkOutput("t6_busy_cycles", 32'(busy_cnt), 32'(64 + 15 * GAP_EN));
        checkOutput("t6_done_pulses", 32'(done_cnt), 32'd1);
        sampleCycle();
        checkOutput("t6_idle_after", 32'(busy), 32'd0);

        // Randomized traffic checked against the model.
        for (int k = 0; k < 400; k++)
            applyStimulus($urandom_range(0, 5) == 0, 4'($urandom), 4'($urandom_range(0, 3)));
        idleCycles(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
